// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the GPIOA Wishbone slave: register offsets, edge
// polarity encoding and small mask helpers.
package calsoc_gpio_pkg;

   localparam int unsigned GPIO_MAX_WIDTH = 32;

   // Word offsets within the 64-byte window (adr[5:2]); 9..15 are unmapped
   typedef enum logic [3:0] {
      GPIO_OUT      = 4'd0,
      GPIO_DIR      = 4'd1,
      GPIO_IN       = 4'd2,
      GPIO_SET      = 4'd3,
      GPIO_CLR      = 4'd4,
      GPIO_TGL      = 4'd5,
      GPIO_IRQ_EN   = 4'd6,
      GPIO_IRQ_EDGE = 4'd7,
      GPIO_IRQ_STAT = 4'd8
   } gpio_reg_e;

   // Per-pin interrupt edge polarity as stored in IRQ_EDGE
   typedef enum logic {
      GPIO_EDGE_RISE = 1'b0,
      GPIO_EDGE_FALL = 1'b1
   } gpio_edge_e;

   // Expand the 4-bit byte select into a 32-bit bit mask
   function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/wb_gpio_if.sv
// Wishbone pipelined bus bundle between the crossbar slave port and wb_gpio.
// Signal names keep the slave-side direction suffixes of the block pinout.
interface wb_gpio_if;

   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_stall_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
   );

endinterface

// File: rtl/wb_gpio_sync.sv
// gpio_sync: WIDTH-wide two-flop synchronizer for asynchronous pad inputs,
// with single-cycle rise/fall pulses derived from the synchronized value.
module gpio_sync #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] prev;
   logic [1:0]       settle;

   // Two-stage synchronizer, previous-cycle copy and post-reset settle counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta   <= '0;
         stable <= '0;
         prev   <= '0;
         settle <= '0;
      end else begin
         meta   <= async_in;
         stable <= meta;
         prev   <= stable;
         if (settle != 2'd3) begin
            settle <= settle + 2'd1;
         end
      end
   end

   assign sync_out = stable;

   // Edge pulses stay masked until prev holds a genuine synchronized sample,
   // so pins already high at reset release never look like a rising edge
   always_comb begin
      rise = '0;
      fall = '0;
      if (settle == 2'd3) begin
         rise = stable & ~prev;
         fall = ~stable & prev;
      end
   end

endmodule

// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone pipelined GPIO bank for the GPIOA crossbar slot.
// Per-pin direction, atomic set/clear/toggle, synchronized readback.
// Define GPIO_IRQ_EN to build the edge-interrupt block (IRQ_EN, IRQ_EDGE,
// IRQ_STAT, irq_o); without it offsets 6..8 read 0, writes are acked and
// dropped, and irq_o is tied low.
module wb_gpio
   import calsoc_gpio_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter logic [31:0] OUT_RESET = '0
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   wb_gpio_if.slave         wb,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe_o,
   output logic             irq_o
);

   logic             req;
   logic             wr;
   logic [3:0]       offset;
   logic             mapped;
   logic [31:0]      bmask;
   logic [31:0]      wdata;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] wm;
   logic [31:0]      rdata;

   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] dir_reg;
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   logic             ack_reg;
   logic             err_reg;
   logic [31:0]      dat_reg;

   assign req    = wb.wb_cyc_i & wb.wb_stb_i;
   assign wr     = req & wb.wb_we_i;
   assign offset = wb.wb_adr_i[5:2];
   assign mapped = (offset <= GPIO_IRQ_STAT);

   // Deselected byte lanes contribute zero, which is also what SET/CLR/TGL/W1C need
   assign bmask = sel_to_mask(wb.wb_sel_i);
   assign wdata = wb.wb_dat_i & bmask;
   assign wd    = wdata[WIDTH-1:0];
   assign wm    = bmask[WIDTH-1:0];

   gpio_sync #(
      .WIDTH (WIDTH)
   ) u_sync (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_ni),
      .async_in (gpio_i),
      .sync_out (in_sync),
      .rise     (rise),
      .fall     (fall)
   );

`ifdef GPIO_IRQ_EN
   logic [WIDTH-1:0] irq_en_reg;
   logic [WIDTH-1:0] irq_edge_reg;
   logic [WIDTH-1:0] irq_stat_reg;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] stat_clr;
   logic             irq_reg;

   // Pick the configured edge polarity per pin
   always_comb begin
      edge_hit = '0;
      for (int n = 0; n < int'(WIDTH); n++) begin
         edge_hit[n] = (gpio_edge_e'(irq_edge_reg[n]) == GPIO_EDGE_FALL) ? fall[n] : rise[n];
      end
   end

   assign stat_clr = (wr && (offset == GPIO_IRQ_STAT)) ? wd : '0;

   // Interrupt configuration, sticky status (new edge beats W1C) and registered irq
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         irq_en_reg   <= '0;
         irq_edge_reg <= '0;
         irq_stat_reg <= '0;
         irq_reg      <= 1'b0;
      end else begin
         if (wr && (offset == GPIO_IRQ_EN)) begin
            irq_en_reg <= (irq_en_reg & ~wm) | wd;
         end
         if (wr && (offset == GPIO_IRQ_EDGE)) begin
            irq_edge_reg <= (irq_edge_reg & ~wm) | wd;
         end
         irq_stat_reg <= (irq_stat_reg & ~stat_clr) | edge_hit;
         irq_reg      <= |(irq_stat_reg & irq_en_reg);
      end
   end

   assign irq_o = irq_reg;
`else
   logic unused_edges;
   assign unused_edges = ^{rise, fall};
   assign irq_o        = 1'b0;
`endif

   // Read-data mux; write-only and unmapped offsets return zero
   always_comb begin
      rdata = '0;
      unique case (offset)
         GPIO_OUT:      rdata[WIDTH-1:0] = out_reg;
         GPIO_DIR:      rdata[WIDTH-1:0] = dir_reg;
         GPIO_IN:       rdata[WIDTH-1:0] = in_sync;
`ifdef GPIO_IRQ_EN
         GPIO_IRQ_EN:   rdata[WIDTH-1:0] = irq_en_reg;
         GPIO_IRQ_EDGE: rdata[WIDTH-1:0] = irq_edge_reg;
         GPIO_IRQ_STAT: rdata[WIDTH-1:0] = irq_stat_reg;
`endif
         default:       rdata = '0;
      endcase
   end

   // Bus response one cycle after acceptance, plus OUT/DIR register updates
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         ack_reg <= 1'b0;
         err_reg <= 1'b0;
         dat_reg <= '0;
         out_reg <= OUT_RESET[WIDTH-1:0];
         dir_reg <= '0;
      end else begin
         ack_reg <= req & mapped;
         err_reg <= req & ~mapped;
         dat_reg <= (req && !wb.wb_we_i && mapped) ? rdata : '0;
         if (wr) begin
            unique case (offset)
               GPIO_OUT: out_reg <= (out_reg & ~wm) | wd;
               GPIO_DIR: dir_reg <= (dir_reg & ~wm) | wd;
               GPIO_SET: out_reg <= out_reg | wd;
               GPIO_CLR: out_reg <= out_reg & ~wd;
               GPIO_TGL: out_reg <= out_reg ^ wd;
               default:  ;
            endcase
         end
      end
   end

   assign wb.wb_ack_o   = ack_reg;
   assign wb.wb_err_o   = err_reg;
   assign wb.wb_dat_o   = dat_reg;
   assign wb.wb_stall_o = 1'b0;

   assign gpio_o    = out_reg;
   assign gpio_oe_o = dir_reg;

   logic unused_bus;
   assign unused_bus = ^{wb.wb_adr_i[31:6], wb.wb_adr_i[1:0], wdata, bmask};

endmodule

// File: tb/tb_wb_gpio.sv
// Directed self-checking bench for wb_gpio: every request pushes its expected
// response to a scoreboard queue, popped when the response cycle arrives.
module tb_wb_gpio;
   import calsoc_gpio_pkg::*;

   localparam int unsigned WIDTH   = 16;
   localparam logic [31:0] OUT_RST = 32'h0000_A5C3;
`ifdef GPIO_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif
   localparam logic [31:0] E8  = IRQ ? 32'h0000_0008 : 32'h0;
   localparam logic [31:0] E20 = IRQ ? 32'h0000_0020 : 32'h0;
   localparam logic [31:0] E28 = IRQ ? 32'h0000_0028 : 32'h0;

   typedef struct {
      string       tag;
      bit          we;
      bit          err;
      logic [31:0] dat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] gpio_in;
   logic [WIDTH-1:0] gpio_out;
   logic [WIDTH-1:0] gpio_oe;
   logic             irq;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   acks  = 0;

   wb_gpio_if bus ();

   wb_gpio #(
      .WIDTH     (WIDTH),
      .OUT_RESET (OUT_RST)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wb        (bus),
      .gpio_i    (gpio_in),
      .gpio_o    (gpio_out),
      .gpio_oe_o (gpio_oe),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Compare the response present after the edge against the scoreboard head
   task automatic collect();
      exp_t e;
      chk("stall", {31'd0, bus.wb_stall_o}, 32'd0);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({e.tag, ".ack"}, {31'd0, bus.wb_ack_o}, {31'd0, !e.err});
         chk({e.tag, ".err"}, {31'd0, bus.wb_err_o}, {31'd0, e.err});
         if (!e.we || e.err) chk({e.tag, ".dat"}, bus.wb_dat_o, e.dat);
         if (bus.wb_ack_o) acks++;
      end else begin
         chk("idle.resp", {30'd0, bus.wb_ack_o, bus.wb_err_o}, 32'd0);
      end
   endtask

   task automatic access(input bit we, input logic [3:0] off, input logic [31:0] d,
                         input logic [3:0] sel, input logic [31:0] exp_d, input string tag);
      exp_t e;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = {26'd0, off, 2'b00};
      bus.wb_dat_i = d;
      bus.wb_sel_i = sel;
      e.tag = tag;
      e.we  = we;
      e.err = (off > 4'd8);
      e.dat = e.err ? 32'd0 : exp_d;
      sb.push_back(e);
      @(posedge clk);
      #1;
      collect();
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] sel,
                     input string tag);
      access(1'b1, off, d, sel, 32'd0, tag);
   endtask

   task automatic rd(input logic [3:0] off, input logic [31:0] exp_d, input string tag);
      access(1'b0, off, 32'd0, 4'hF, exp_d, tag);
   endtask

   task automatic idle(input int n);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         collect();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] model;
      logic [31:0] d;
      int          acks0;

      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_sel_i = '0;
      gpio_in      = '0;
      rst_n        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.ack", {31'd0, bus.wb_ack_o}, 32'd0);
      chk("rst.err", {31'd0, bus.wb_err_o}, 32'd0);
      chk("rst.dat", bus.wb_dat_o, 32'd0);
      chk("rst.irq", {31'd0, irq}, 32'd0);
      chk("rst.gpio_o", {16'd0, gpio_out}, OUT_RST);
      chk("rst.gpio_oe", {16'd0, gpio_oe}, 32'd0);
      rst_n = 1'b1;

      // Reset values of every mapped offset, then unmapped accesses
      rd(4'd0, OUT_RST, "rst.out");
      rd(4'd1, 32'd0, "rst.dir");
      rd(4'd2, 32'd0, "rst.in");
      rd(4'd3, 32'd0, "rst.set");
      rd(4'd4, 32'd0, "rst.clr");
      rd(4'd5, 32'd0, "rst.tgl");
      rd(4'd6, 32'd0, "rst.irq_en");
      rd(4'd7, 32'd0, "rst.irq_edge");
      rd(4'd8, 32'd0, "rst.irq_stat");
      rd(4'd12, 32'd0, "unmapped.rd12");
      idle(1);
      chk("rst.irq2", {31'd0, irq}, 32'd0);

      // DIR, OUT and the atomic set/clear/toggle ports
      wr(4'd1, 32'h0000_00FF, 4'hF, "dir.wr");
      wr(4'd0, 32'h0000_1234, 4'hF, "out.wr");
      wr(4'd3, 32'h0000_0001, 4'hF, "set.wr");
      wr(4'd4, 32'h0000_0030, 4'hF, "clr.wr");
      wr(4'd5, 32'h0000_8000, 4'hF, "tgl.wr");
      chk("atomic.gpio_oe", {16'd0, gpio_oe}, 32'h0000_00FF);
      chk("atomic.gpio_o", {16'd0, gpio_out}, 32'h0000_9205);
      rd(4'd0, 32'h0000_9205, "atomic.out");
      rd(4'd1, 32'h0000_00FF, "atomic.dir");
      rd(4'd3, 32'd0, "wo.set");
      rd(4'd4, 32'd0, "wo.clr");
      rd(4'd5, 32'd0, "wo.tgl");
      wr(4'd2, 32'h0000_FFFF, 4'hF, "in.wr");
      rd(4'd2, 32'd0, "in.ro");

      // Byte-lane selects on plain and atomic writes, bits above WIDTH
      wr(4'd0, 32'd0, 4'hF, "sel.clear");
      wr(4'd0, 32'h0000_FFFF, 4'b0001, "sel.out");
      rd(4'd0, 32'h0000_00FF, "sel.out");
      wr(4'd3, 32'h0000_FFFF, 4'b0010, "sel.set");
      rd(4'd0, 32'h0000_FFFF, "sel.set");
      wr(4'd4, 32'h0000_FFFF, 4'b0001, "sel.clr");
      rd(4'd0, 32'h0000_FF00, "sel.clr");
      wr(4'd0, 32'hFFFF_FFFF, 4'hF, "width.wr");
      rd(4'd0, 32'h0000_FFFF, "width.out");
      wr(4'd9, 32'd0, 4'hF, "unmapped.wr9");
      rd(4'd0, 32'h0000_FFFF, "unmapped.nochg");

      // Rising edge on pin 3: IN after 2 cycles, status after 3, irq after 4
      wr(4'd7, 32'd0, 4'hF, "edge.cfg");
      wr(4'd6, 32'h0000_0008, 4'hF, "en.cfg");
      rd(4'd6, E8, "en.rd");
      gpio_in = 16'h0008;
      rd(4'd2, 32'd0, "in.lat1");
      chk("irq.lat1", {31'd0, irq}, 32'd0);
      rd(4'd2, 32'd0, "in.lat2");
      chk("irq.lat2", {31'd0, irq}, 32'd0);
      rd(4'd2, 32'h0000_0008, "in.lat3");
      chk("irq.lat3", {31'd0, irq}, 32'd0);
      rd(4'd8, E8, "stat.rise");
      chk("irq.lat4", {31'd0, irq}, {31'd0, IRQ});
      wr(4'd8, 32'h0000_0008, 4'hF, "w1c.3");
      chk("irq.w1c1", {31'd0, irq}, {31'd0, IRQ});
      idle(1);
      chk("irq.w1c2", {31'd0, irq}, 32'd0);
      rd(4'd8, 32'd0, "stat.cleared");

      // Falling edge on pin 5 coinciding with W1C of a pending bit 5
      wr(4'd7, 32'h0000_0020, 4'hF, "edge.fall");
      wr(4'd6, 32'h0000_0028, 4'hF, "en.fall");
      rd(4'd7, E20, "edge.rd");
      gpio_in = 16'h0028;
      idle(4);
      rd(4'd2, 32'h0000_0028, "in.pin5");
      rd(4'd8, 32'd0, "stat.norise");
      gpio_in = 16'h0008;
      idle(1);
      gpio_in = 16'h0028;
      idle(3);
      rd(4'd8, E20, "stat.fall1");
      chk("irq.fall1", {31'd0, irq}, {31'd0, IRQ});
      gpio_in = 16'h0008;
      idle(1);
      gpio_in = 16'h0028;
      idle(1);
      wr(4'd8, 32'h0000_0020, 4'hF, "w1c.race");
      rd(4'd8, E20, "stat.setwins");
      wr(4'd8, 32'h0000_0020, 4'hF, "w1c.5");
      rd(4'd8, 32'd0, "stat.clr5");
      rd(4'd6, E28, "en.rd2");
      idle(1);
      chk("irq.final", {31'd0, irq}, 32'd0);

      // Sixteen back-to-back accesses, one per cycle
      acks0 = acks;
      model = 32'h0000_FFFF;
      for (int i = 0; i < 16; i++) begin
         if ((i % 2) == 0) begin
            d     = 32'hA5A5_0000 ^ (32'h0000_1357 * (i + 1));
            model = d & 32'h0000_FFFF;
            wr(4'd0, d, 4'hF, "b2b.wr");
            chk("b2b.gpio_o", {16'd0, gpio_out}, model);
         end else begin
            rd(4'd0, model, "b2b.rd");
         end
         chk("b2b.irq", {31'd0, irq}, 32'd0);
      end
      idle(1);
      chk("b2b.acks", acks - acks0, 32'd16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
